// File: rtl/exe_unit_sched.sv
// exe_unit_sched: round-robin scheduler for two requesters sharing the SPI execution datapath.
// Accepts one request at a time, holds it on the datapath for EXE_LAT cycles, then returns the result.
module exe_unit_sched #(
   parameter int m       = 4,
   parameter int NUM_OPS = 5,
   parameter int EXE_LAT = 1
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_req0_valid,
   output logic         o_req0_ready,
   input  logic [2:0]   i_req0_op,
   input  logic [m-1:0] i_req0_argA,
   input  logic [m-1:0] i_req0_argB,
   input  logic         i_req1_valid,
   output logic         o_req1_ready,
   input  logic [2:0]   i_req1_op,
   input  logic [m-1:0] i_req1_argA,
   input  logic [m-1:0] i_req1_argB,
   output logic         o_exe_start,
   output logic [2:0]   o_exe_op,
   output logic [m-1:0] o_exe_argA,
   output logic [m-1:0] o_exe_argB,
   input  logic [m-1:0] i_exe_result,
   output logic         o_rsp_valid,
   input  logic         i_rsp_ready,
   output logic         o_rsp_id,
   output logic [m-1:0] o_rsp_result,
   output logic         o_rsp_err,
   output logic         o_busy
);
   localparam int CW = (EXE_LAT > 1) ? $clog2(EXE_LAT) : 1;
   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
   state_t state_q, state_d;
   logic last_q, last_d, id_q, id_d, err_q, err_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0] op_q, op_d;
   logic [m-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
   logic gnt0, gnt1, idle, issue, lat_done;
   logic [2:0] acc_op;
   always_comb begin
      idle     = state_q == IDLE;
      issue    = state_q == ISSUE;
      // on a tie the requester that did not win last time gets the grant
      gnt1     = i_req1_valid && (!i_req0_valid || !last_q);
      gnt0     = i_req0_valid && !gnt1;
      acc_op   = gnt1 ? i_req1_op : i_req0_op;
      lat_done = cnt_q == CW'(EXE_LAT - 1);
      state_d  = state_q;
      last_d   = last_q;
      id_d     = id_q;
      err_d    = err_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      a_d      = a_q;
      b_d      = b_q;
      res_d    = res_q;
      case (state_q)
         IDLE: if (gnt0 || gnt1) begin
            id_d   = gnt1;
            last_d = gnt1;
            op_d   = acc_op;
            a_d    = gnt1 ? i_req1_argA : i_req0_argA;
            b_d    = gnt1 ? i_req1_argB : i_req0_argB;
            cnt_d  = '0;
            if (32'(acc_op) < NUM_OPS) state_d = ISSUE;
            else begin
               state_d = RESP;
               err_d   = 1'b1;
               res_d   = '0;
            end
         end
         ISSUE: if (lat_done) begin
            state_d = RESP;
            res_d   = i_exe_result;
            err_d   = 1'b0;
         end else cnt_d = cnt_q + 1'b1;
         RESP: state_d = i_rsp_ready ? IDLE : RESP;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         last_q  <= 1'b1;
         id_q    <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
         id_q    <= id_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         res_q   <= res_d;
      end
   end
   assign o_req0_ready = i_rst_n && idle && gnt0;
   assign o_req1_ready = i_rst_n && idle && gnt1;
   assign o_exe_start  = issue && cnt_q == '0;
   assign o_exe_op     = issue ? op_q : '0;
   assign o_exe_argA   = issue ? a_q : '0;
   assign o_exe_argB   = issue ? b_q : '0;
   assign o_rsp_valid  = state_q == RESP;
   assign o_rsp_id     = id_q;
   assign o_rsp_result = res_q;
   assign o_rsp_err    = err_q;
   assign o_busy       = !idle;
endmodule

// File: tb/tb_exe_unit_sched.sv
// tb_exe_unit_sched: random traffic on EXE_LAT=1 and EXE_LAT=3 instances against a timestamp-based reference.
module tb_exe_unit_sched;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int unsigned cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   int n_chk = 0, n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // datapath stand-in; mixing in the cycle number exposes a result captured on the wrong cycle
   function automatic logic [3:0] dp(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                                     input int unsigned c);
      logic [3:0] r;
      case (op)
         3'd0: r = a + b;
         3'd1: r = a - b;
         3'd2: r = a & b;
         3'd3: r = a ^ b;
         default: r = 4'($countones(a) + $countones(b));
      endcase
      return r ^ c[3:0];
   endfunction

   for (genvar g = 0; g < 2; g++) begin : gen_u
      localparam int L = (g == 0) ? 1 : 3;
      logic rst_n, v0, v1, r0, r1, rdy, st, rv, rid, rerr, busy;
      logic [2:0] op0, op1, eop;
      logic [3:0] a0, b0, a1, b1, ea, eb, res, rres;
      bit done = 1'b0;
      bit have, legal, last, mid, acc0, acc1;
      logic [2:0] mop;
      logic [3:0] ma, mb;
      int unsigned t_acc;

      assign res = dp(eop, ea, eb, cyc);

      exe_unit_sched #(.m(4), .NUM_OPS(5), .EXE_LAT(L)) u_dut (
         .i_clk(clk), .i_rst_n(rst_n),
         .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_op(op0), .i_req0_argA(a0), .i_req0_argB(b0),
         .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_op(op1), .i_req1_argA(a1), .i_req1_argB(b1),
         .o_exe_start(st), .o_exe_op(eop), .o_exe_argA(ea), .o_exe_argB(eb), .i_exe_result(res),
         .o_rsp_valid(rv), .i_rsp_ready(rdy), .o_rsp_id(rid), .o_rsp_result(rres), .o_rsp_err(rerr),
         .o_busy(busy));

      // a transaction accepted in cycle t_acc issues in t_acc+1..t_acc+L and responds from t_acc+L+1
      function automatic bit in_issue(input int unsigned c);
         return have && legal && c > t_acc && c <= t_acc + L;
      endfunction
      function automatic bit in_resp(input int unsigned c);
         return have && c >= t_acc + (legal ? L + 1 : 1);
      endfunction

      task automatic check_cycle();
         int unsigned c;
         bit iss, rsp, w1;
         c   = cyc;
         iss = in_issue(c);
         rsp = in_resp(c);
         w1  = v1 && (!v0 || !last);
         check("busy", busy, have);
         check("ready0", r0, !have && v0 && !w1);
         check("ready1", r1, !have && w1);
         check("exe_start", st, iss && c == t_acc + 1);
         check("exe_op", eop, iss ? mop : 3'd0);
         check("exe_argA", ea, iss ? ma : 4'd0);
         check("exe_argB", eb, iss ? mb : 4'd0);
         check("rsp_valid", rv, rsp);
         if (rsp) begin
            check("rsp_id", rid, mid);
            check("rsp_err", rerr, !legal);
            check("rsp_result", rres, legal ? dp(mop, ma, mb, t_acc + L) : 4'd0);
         end
      endtask

      task automatic step();
         int unsigned c;
         bit w1;
         c    = cyc;
         w1   = v1 && (!v0 || !last);
         acc0 = 1'b0;
         acc1 = 1'b0;
         if (!have && (v0 || v1)) begin
            have  = 1'b1;
            t_acc = c;
            last  = w1;
            mid   = w1;
            acc0  = !w1;
            acc1  = w1;
            mop   = w1 ? op1 : op0;
            ma    = w1 ? a1 : a0;
            mb    = w1 ? b1 : b0;
            legal = mop < 3'd5;
         end else if (in_resp(c) && rdy) have = 1'b0;
      endtask

      task automatic drive();
         if (!v0 || acc0) begin
            v0  = $urandom_range(0, 9) < 6;
            op0 = 3'($urandom_range(0, 7));
            a0  = 4'($urandom);
            b0  = 4'($urandom);
         end
         if (!v1 || acc1) begin
            v1  = $urandom_range(0, 9) < 6;
            op1 = 3'($urandom_range(0, 7));
            a1  = 4'($urandom);
            b1  = 4'($urandom);
         end
         rdy = $urandom_range(0, 9) < 5;
      endtask

      task automatic async_reset();
         rst_n = 1'b0;
         #1;
         check("rst_busy", busy, 0);
         check("rst_ready0", r0, 0);
         check("rst_ready1", r1, 0);
         check("rst_exe_start", st, 0);
         check("rst_exe_op", eop, 0);
         check("rst_exe_argA", ea, 0);
         check("rst_exe_argB", eb, 0);
         check("rst_rsp_valid", rv, 0);
         check("rst_rsp_id", rid, 0);
         check("rst_rsp_result", rres, 0);
         check("rst_rsp_err", rerr, 0);
         have = 1'b0;
         last = 1'b1;
         acc0 = 1'b0;
         acc1 = 1'b0;
         v0   = 1'b1;
         v1   = 1'b1;
         op0  = 3'($urandom_range(0, 7));
         op1  = 3'($urandom_range(0, 7));
         @(posedge clk);
         #1 rst_n = 1'b1;
      endtask

      initial begin
         int n_iss, n_rsp;
         n_iss = 0;
         n_rsp = 0;
         rst_n = 1'b0;
         {v0, v1, rdy} = '0;
         {op0, op1} = '0;
         {a0, b0, a1, b1} = '0;
         {have, legal, mid, acc0, acc1} = '0;
         last  = 1'b1;
         t_acc = 0;
         mop   = '0;
         ma    = '0;
         mb    = '0;
         repeat (2) @(negedge clk);
         check_cycle();
         v0 = 1'b1;
         v1 = 1'b1;
         @(posedge clk);
         #1 rst_n = 1'b1;
         for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            check_cycle();
            step();
            @(posedge clk);
            #1;
            if (i > 100 && n_iss < 3 && in_issue(cyc)) begin
               async_reset();
               n_iss++;
            end else if (i > 100 && n_rsp < 3 && in_resp(cyc)) begin
               async_reset();
               n_rsp++;
            end else drive();
         end
         check("resets_in_issue", n_iss, 3);
         check("resets_in_resp", n_rsp, 3);
         done = 1'b1;
      end
   end

   initial begin
      for (int i = 0; i < 20000 && !(gen_u[0].done && gen_u[1].done); i++) @(posedge clk);
      check("finished", 32'(gen_u[0].done && gen_u[1].done), 1);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
